// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA video SRAM arbiter.
// The optional CPU wait-state mode is selected with CGA_BUS_WAIT_EN.
package cga_pkg;

    localparam int RAM_AW = 19;

    localparam logic [4:0] ISA_WIN_START = 5'd17;
    localparam logic [4:0] ISA_WIN_END   = 5'd20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_WIN = 2'd1,
        ACCESS   = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    // The window never wraps, so a plain unsigned range test is enough.
    function automatic logic in_window(input logic [4:0] seq,
                                       input logic [4:0] win_start,
                                       input logic [4:0] win_end);
        return (seq >= win_start) && (seq <= win_end);
    endfunction

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// ISA-side bus bundle of the CGA video SRAM arbiter.
// Under CGA_BUS_WAIT_EN the bus_rdy signal carries real wait states.
interface cga_vram_arbiter_if;
    import cga_pkg::*;

    logic [RAM_AW-1:0] isa_addr;
    logic [7:0]        isa_din;
    logic              isa_read;
    logic              isa_write;
    logic [7:0]        isa_dout;
    logic              bus_rdy;

    modport master (
        output isa_addr, isa_din, isa_read, isa_write,
        input  isa_dout, bus_rdy
    );

    modport slave (
        input  isa_addr, isa_din, isa_read, isa_write,
        output isa_dout, bus_rdy
    );

endinterface

// File: rtl/cga_isa_capture.sv
// ISA strobe edge detection, request latch and write/read priority.
// CGA_BUS_WAIT_EN drops the posted-write behaviour and drives bus_rdy.
module cga_isa_capture
    import cga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RAM_AW-1:0] isa_addr,
    input  logic [7:0]        isa_din,
    input  logic              isa_read,
    input  logic              isa_write,
    input  logic              complete,
    output logic              req_valid,
    output logic              req_write,
    output logic [RAM_AW-1:0] req_addr,
    output logic [7:0]        req_data,
    output logic              bus_rdy,
    output logic              wr_overrun
);

    logic              read_q, write_q;
    logic              wr_pend, rd_pend;
    logic [RAM_AW-1:0] wr_addr, rd_addr;
    logic [7:0]        wr_data;
    logic              accept, write_take, read_take;
    logic              serve_wr, serve_rd;

`ifdef CGA_BUS_WAIT_EN
    // The CPU is stalled while busy, so there is nothing to queue.
    assign accept = ~(wr_pend | rd_pend);
`else
    assign accept = 1'b1;
`endif

    assign write_take = isa_write & ~write_q & accept;
    assign read_take  = isa_read & ~read_q & ~(isa_write & ~write_q) & accept;
    assign serve_wr   = complete & wr_pend;
    assign serve_rd   = complete & ~wr_pend & rd_pend;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            read_q  <= isa_read;
            write_q <= isa_write;
            wr_pend <= write_take | (wr_pend & ~serve_wr);
            rd_pend <= read_take  | (rd_pend & ~serve_rd);
        end
    end

    // NOTE: address/data holders need no reset; the pending bits qualify them.
    always_ff @(posedge clk) begin
        if (write_take) begin
            wr_addr <= isa_addr;
            wr_data <= isa_din;
        end
        if (read_take)
            rd_addr <= isa_addr;
    end

`ifdef CGA_BUS_WAIT_EN
    logic rdy_q;

    always_ff @(posedge clk) begin
        if (reset)
            rdy_q <= 1'b1;
        else if (complete)
            rdy_q <= 1'b1;
        else if (write_take | read_take)
            rdy_q <= 1'b0;
    end

    assign bus_rdy    = rdy_q;
    assign wr_overrun = 1'b0;
`else
    logic overrun_q;

    // A write that completes this cycle is not lost by a new edge.
    always_ff @(posedge clk) begin
        if (reset)
            overrun_q <= 1'b0;
        else if (write_take & wr_pend & ~serve_wr)
            overrun_q <= 1'b1;
    end

    assign bus_rdy    = 1'b1;
    assign wr_overrun = overrun_q;
`endif

    assign req_valid = wr_pend | rd_pend;
    assign req_write = wr_pend;
    assign req_addr  = wr_pend ? wr_addr : rd_addr;
    assign req_data  = wr_data;

endmodule

// File: rtl/cga_vram_arbiter.sv
// CGA video SRAM arbiter: pixel fetch always wins, CPU accesses in a clk_seq window.
// Define CGA_BUS_WAIT_EN to hold the ISA bus with bus_rdy instead of posting writes.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter logic [4:0] WIN_START = ISA_WIN_START,
    parameter logic [4:0] WIN_END   = ISA_WIN_END
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        clk_seq,
    cga_vram_arbiter_if.slave isa,
    output logic              wr_overrun,
    input  logic [RAM_AW-1:0] pixel_addr,
    input  logic              pixel_read,
    output logic [7:0]        pixel_data,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_d_out,
    output logic              ram_d_oe,
    input  logic [7:0]        ram_d_in,
    output logic              ram_we_l
);

    arb_state_t        state, state_next;
    logic              complete, cpu_owns;
    logic              req_valid, req_write;
    logic [RAM_AW-1:0] req_addr;
    logic [7:0]        req_data;
    logic [7:0]        isa_dout_q;

    cga_isa_capture u_capture (
        .clk        (clk),
        .reset      (reset),
        .isa_addr   (isa.isa_addr),
        .isa_din    (isa.isa_din),
        .isa_read   (isa.isa_read),
        .isa_write  (isa.isa_write),
        .complete   (complete),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .bus_rdy    (isa.bus_rdy),
        .wr_overrun (wr_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE:     if (req_valid) state_next = WAIT_WIN;
            WAIT_WIN: if (in_window(clk_seq, WIN_START, WIN_END) && !pixel_read)
                          state_next = ACCESS;
            ACCESS: begin
                if (pixel_read) begin
                    state_next = WAIT_WIN;
                end else begin
                    state_next = DONE;
                    complete   = 1'b1;
                end
            end
            DONE: begin
`ifdef CGA_BUS_WAIT_EN
                if (!isa.isa_read && !isa.isa_write) state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default:  state_next = IDLE;
        endcase
    end

    // Strobes decode only from the state register and pixel_read, so no glitches.
    assign cpu_owns = (state == ACCESS) && !pixel_read;

    always_comb begin
        ram_a    = pixel_addr;
        ram_d_oe = 1'b0;
        ram_we_l = 1'b1;
        if (cpu_owns) begin
            ram_a    = req_addr;
            ram_d_oe = req_write;
            ram_we_l = ~req_write;
        end
    end

    assign ram_d_out = req_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            isa_dout_q <= 8'h00;
            pixel_data <= 8'h00;
        end else begin
            if (cpu_owns && !req_write) isa_dout_q <= ram_d_in;
            if (pixel_read)             pixel_data <= ram_d_in;
        end
    end

    assign isa.isa_dout = isa_dout_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed self-checking bench for cga_vram_arbiter (default build and CGA_BUS_WAIT_EN).
module tb_cga_vram_arbiter;
    import cga_pkg::*;

    logic              clk;
    logic              reset;
    logic [4:0]        clk_seq;
    logic              wr_overrun;
    logic [RAM_AW-1:0] pixel_addr;
    logic              pixel_read;
    logic [7:0]        pixel_data;
    logic [RAM_AW-1:0] ram_a;
    logic [7:0]        ram_d_out;
    logic              ram_d_oe;
    logic [7:0]        ram_d_in;
    logic              ram_we_l;

    cga_vram_arbiter_if isa_bus ();

    cga_vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .clk_seq    (clk_seq),
        .isa        (isa_bus),
        .wr_overrun (wr_overrun),
        .pixel_addr (pixel_addr),
        .pixel_read (pixel_read),
        .pixel_data (pixel_data),
        .ram_a      (ram_a),
        .ram_d_out  (ram_d_out),
        .ram_d_oe   (ram_d_oe),
        .ram_d_in   (ram_d_in),
        .ram_we_l   (ram_we_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read, write on the edge closing a we_l=0 cycle.
    logic [7:0]  mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_a  = '0;
    logic [7:0]  poke_d  = '0;
    int          wr_cnt  = 0;
    logic [RAM_AW-1:0] last_a   = '0;
    logic [7:0]  last_d   = '0;
    logic [4:0]  last_seq = '0;
    logic        last_oe  = 1'b0;

    assign ram_d_in = mem[ram_a[9:0]];

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_a] <= poke_d;
        end else if (!reset && !ram_we_l) begin
            mem[ram_a[9:0]] <= ram_d_out;
            wr_cnt   <= wr_cnt + 1;
            last_a   <= ram_a;
            last_d   <= ram_d_out;
            last_seq <= clk_seq;
            last_oe  <= ram_d_oe;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clk_seq = clk_seq + 5'd1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        next_cycle();
        poke_en = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        clk_seq           = 5'd0;
        pixel_addr        = '0;
        pixel_read        = 1'b0;
        isa_bus.isa_addr  = '0;
        isa_bus.isa_din   = '0;
        isa_bus.isa_read  = 1'b0;
        isa_bus.isa_write = 1'b0;

        poke(10'h123, 8'hA5);
        poke(10'h010, 8'h5A);
        poke(10'h080, 8'h99);
        poke(10'h200, 8'h77);
        poke(10'h001, 8'h00);
        poke(10'h002, 8'h00);
        reset = 1'b0;
        #1;
        check("rst_bus_rdy",    32'(isa_bus.bus_rdy),  32'h1);
        check("rst_we_l",       32'(ram_we_l),         32'h1);
        check("rst_d_oe",       32'(ram_d_oe),         32'h0);
        check("rst_isa_dout",   32'(isa_bus.isa_dout), 32'h00);
        check("rst_pixel_data", 32'(pixel_data),       32'h00);
        check("rst_overrun",    32'(wr_overrun),       32'h0);

        // Idle pixel fetch
        next_cycle();
        pixel_read = 1'b1;
        pixel_addr = 19'h00123;
        #1;
        check("pix_ram_a", 32'(ram_a),    32'h00123);
        check("pix_we_l",  32'(ram_we_l), 32'h1);
        next_cycle();
        pixel_read = 1'b0;
        check("pix_data",  32'(pixel_data), 32'hA5);

        // CPU write outside the window: ACCESS lands at clk_seq 18
        next_cycle();
        clk_seq           = 5'd5;
        isa_bus.isa_addr  = 19'h00040;
        isa_bus.isa_din   = 8'h3C;
        isa_bus.isa_write = 1'b1;
        base = wr_cnt;
        next_cycle();
        isa_bus.isa_write = 1'b0;
        repeat (19) next_cycle();
        check("wr_count", 32'(wr_cnt - base), 32'd1);
        check("wr_addr",  32'(last_a),        32'h00040);
        check("wr_data",  32'(last_d),        32'h3C);
        check("wr_seq",   32'(last_seq),      32'd18);
        check("wr_oe",    32'(last_oe),       32'h1);
        check("wr_mem",   32'(mem[10'h040]),  32'h3C);

        // Preemption of a CPU read during ACCESS
        clk_seq          = 5'd14;
        isa_bus.isa_addr = 19'h00010;
        isa_bus.isa_read = 1'b1;
        next_cycle();                     // 15
        next_cycle();                     // 16
        isa_bus.isa_read = 1'b0;
        next_cycle();                     // 17
        next_cycle();                     // 18: ACCESS, pixel takes it
        pixel_read = 1'b1;
        pixel_addr = 19'h00123;
        #1;
        check("pre_ram_a", 32'(ram_a),    32'h00123);
        check("pre_we_l",  32'(ram_we_l), 32'h1);
        check("pre_d_oe",  32'(ram_d_oe), 32'h0);
        next_cycle();                     // 19: WAIT_WIN retry
        pixel_read = 1'b0;
        check("pre_pix_data",  32'(pixel_data),       32'hA5);
        check("pre_dout_hold", 32'(isa_bus.isa_dout), 32'h00);
        next_cycle();                     // 20: retried ACCESS
        #1;
        check("pre_retry_a", 32'(ram_a), 32'h00010);
        next_cycle();                     // 21
        check("pre_dout", 32'(isa_bus.isa_dout), 32'h5A);

        // Simultaneous read and write edges: only the write runs
        next_cycle();
        clk_seq           = 5'd14;
        isa_bus.isa_addr  = 19'h00080;
        isa_bus.isa_din   = 8'hC3;
        isa_bus.isa_read  = 1'b1;
        isa_bus.isa_write = 1'b1;
        base = wr_cnt;
        next_cycle();
        isa_bus.isa_read  = 1'b0;
        isa_bus.isa_write = 1'b0;
        repeat (40) next_cycle();
        check("sim_count",  32'(wr_cnt - base),    32'd1);
        check("sim_addr",   32'(last_a),           32'h00080);
        check("sim_data",   32'(last_d),           32'hC3);
        check("sim_dout",   32'(isa_bus.isa_dout), 32'h5A);
        check("sim_mem",    32'(mem[10'h080]),     32'hC3);
        check("sim_ovr",    32'(wr_overrun),       32'h0);

`ifdef CGA_BUS_WAIT_EN
        // Wait-state read
        clk_seq          = 5'd14;
        isa_bus.isa_addr = 19'h00200;
        isa_bus.isa_read = 1'b1;
        next_cycle();                     // 15
        check("wt_rdy_low", 32'(isa_bus.bus_rdy), 32'h0);
        repeat (4) next_cycle();          // 19: DONE
        check("wt_rdy_high", 32'(isa_bus.bus_rdy),  32'h1);
        check("wt_dout",     32'(isa_bus.isa_dout), 32'h77);
        next_cycle();                     // 20
        next_cycle();                     // 21
        check("wt_hold_done", 32'(dut.state), 32'(DONE));
        isa_bus.isa_read = 1'b0;
        next_cycle();                     // 22
        check("wt_idle", 32'(dut.state), 32'(IDLE));
        check("wt_ovr",  32'(wr_overrun), 32'h0);
`else
        // Posted-write overrun
        clk_seq           = 5'd5;
        isa_bus.isa_addr  = 19'h00001;
        isa_bus.isa_din   = 8'h11;
        isa_bus.isa_write = 1'b1;
        base = wr_cnt;
        next_cycle();                     // 6
        isa_bus.isa_write = 1'b0;
        next_cycle();                     // 7
        isa_bus.isa_addr  = 19'h00002;
        isa_bus.isa_din   = 8'h22;
        isa_bus.isa_write = 1'b1;
        next_cycle();                     // 8
        isa_bus.isa_write = 1'b0;
        check("ovr_set", 32'(wr_overrun), 32'h1);
        repeat (20) next_cycle();
        check("ovr_count", 32'(wr_cnt - base), 32'd1);
        check("ovr_addr",  32'(last_a),        32'h00002);
        check("ovr_data",  32'(last_d),        32'h22);
        check("ovr_mem1",  32'(mem[10'h001]),  32'h00);
        check("ovr_bus_rdy", 32'(isa_bus.bus_rdy), 32'h1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("ovr_clear", 32'(wr_overrun), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
